// File: rtl/ddr_readback_pkg.sv
// Shared constants, FSM state type and width helpers for the DDR readback engine.
package ddr_readback_pkg;

  localparam int unsigned BEAT_BYTES     = 32;
  localparam int unsigned PAGE_BYTES     = 4096;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

  // Pointer width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // Bits needed to hold the values 0..v inclusive.
  function automatic int unsigned count_bits(input int unsigned v);
    return $clog2(v + 1);
  endfunction

endpackage

// File: rtl/ddr_readback_engine_fifo.sv
// First-word-fall-through synchronous FIFO buffering R beats towards the stream port.
module readback_fifo
  import ddr_readback_pkg::*;
#(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              pop_data,
  output logic                          empty,
  output logic [count_bits(DEPTH)-1:0]  count
);

  localparam int unsigned PtrW = clog2_min1(DEPTH);
  localparam int unsigned CntW = count_bits(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             full, do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO can still accept a beat when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/ddr_readback_engine.sv
// AXI4 read master: splits a (base, beat count) command into 4 KB-safe INCR bursts,
// reserves FIFO space per burst with credits and streams the returned beats out.
module ddr_readback_engine
  import ddr_readback_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH  = 35,
  parameter int unsigned AXI_DATA_WIDTH  = 8 * BEAT_BYTES,
  parameter int unsigned BURST_BEATS     = 16,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned COUNT_WIDTH     = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [COUNT_WIDTH-1:0]    beat_count,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast
);

  localparam int unsigned BeatBytes = AXI_DATA_WIDTH / 8;
  localparam int unsigned BeatShift = $clog2(BeatBytes);
  localparam int unsigned FifoDepth = MAX_OUTSTANDING * BURST_BEATS;
  localparam int unsigned CredW     = count_bits(FifoDepth);
  localparam int unsigned LenW      = 9;
  localparam int unsigned QPtrW     = clog2_min1(MAX_OUTSTANDING);
  localparam int unsigned QCntW     = count_bits(MAX_OUTSTANDING);
  localparam logic [AXI_ADDR_WIDTH-1:0] AddrMask = AXI_ADDR_WIDTH'(BeatBytes - 1);

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [COUNT_WIDTH-1:0]    remaining_q, remaining_d;
  logic [COUNT_WIDTH-1:0]    total_q, total_d;
  logic [COUNT_WIDTH-1:0]    out_cnt_q, out_cnt_d;
  logic [CredW-1:0]          credits_q, credits_d;
  logic                      error_q, error_d;
  logic                      done_q, done_d;

  // In-flight burst lengths, oldest at rd pointer, plus beat counter for that burst.
  logic [LenW-1:0]           len_q [MAX_OUTSTANDING];
  logic [QPtrW-1:0]          lq_wr_q, lq_rd_q;
  logic [QCntW-1:0]          lq_cnt_q;
  logic [LenW-1:0]           rbeat_q, rbeat_d;

  logic [LenW-1:0]           burst_len;
  logic [12:0]               page_room;
  logic                      ar_hs, r_hs, pop, lq_push, lq_pop, beat_is_last, r_bad;
  logic [CredW-1:0]          fifo_count;
  logic                      fifo_empty;

  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign r_hs  = m_axi_rvalid && m_axi_rready;
  assign pop   = m_axis_tvalid && m_axis_tready;

  // Burst length: capped by the burst limit, the remaining beats and the 4 KB page end.
  always_comb begin
    page_room = (13'(PAGE_BYTES) - {1'b0, addr_q[11:0]}) >> BeatShift;
    burst_len = LenW'(BURST_BEATS);
    if (remaining_q < COUNT_WIDTH'(burst_len)) burst_len = LenW'(remaining_q);
    if (page_room < 13'(burst_len))            burst_len = LenW'(page_room);
  end

  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign error         = error_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(burst_len - LenW'(1));
  assign m_axi_arsize  = 3'(BeatShift);
  assign m_axi_arburst = AXI_BURST_INCR;
  // Only request what the FIFO is guaranteed to absorb, so R is never back-pressured.
  assign m_axi_arvalid = (state_q == StIssue) && (32'(credits_q) >= 32'(burst_len)) &&
                         (lq_cnt_q < QCntW'(MAX_OUTSTANDING));
  assign m_axi_rready  = busy;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tlast  = m_axis_tvalid && (out_cnt_q + COUNT_WIDTH'(1) == total_q);

  assign beat_is_last = (rbeat_q + LenW'(1) == len_q[lq_rd_q]);
  assign r_bad        = (lq_cnt_q == '0) || (m_axi_rresp != AXI_RESP_OKAY) ||
                        (m_axi_rlast != beat_is_last);
  assign lq_push      = ar_hs;
  assign lq_pop       = r_hs && (lq_cnt_q != '0) && beat_is_last;

  // Command FSM and burst splitter next state.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    total_d     = total_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          addr_d      = base_addr & ~AddrMask;
          remaining_d = beat_count;
          total_d     = beat_count;
          if (beat_count == '0) done_d  = 1'b1;
          else                  state_d = StIssue;
        end
      end
      StIssue: begin
        if (ar_hs) begin
          addr_d      = addr_q + (AXI_ADDR_WIDTH'(burst_len) << BeatShift);
          remaining_d = remaining_q - COUNT_WIDTH'(burst_len);
          if (remaining_q == COUNT_WIDTH'(burst_len)) state_d = StDrain;
        end
      end
      StDrain: begin
        // The final tlast pop is the last beat of the command leaving the FIFO.
        if (pop && m_axis_tlast && fifo_count == CredW'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Credits, output beat counter, R beat tracking and sticky error next state.
  always_comb begin
    credits_d = credits_q;
    out_cnt_d = out_cnt_q;
    error_d   = error_q;
    rbeat_d   = rbeat_q;
    if (ar_hs) credits_d = credits_d - CredW'(burst_len);
    if (pop) begin
      credits_d = credits_d + CredW'(1);
      out_cnt_d = out_cnt_q + COUNT_WIDTH'(1);
    end
    if (r_hs) begin
      if (r_bad) error_d = 1'b1;
      if (lq_cnt_q != '0) rbeat_d = beat_is_last ? '0 : rbeat_q + LenW'(1);
    end
    if (state_q == StIdle && start) begin
      credits_d = CredW'(FifoDepth);
      out_cnt_d = '0;
      error_d   = 1'b0;
      rbeat_d   = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      total_q     <= '0;
      out_cnt_q   <= '0;
      credits_q   <= CredW'(FifoDepth);
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      rbeat_q     <= '0;
      lq_wr_q     <= '0;
      lq_rd_q     <= '0;
      lq_cnt_q    <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) len_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      total_q     <= total_d;
      out_cnt_q   <= out_cnt_d;
      credits_q   <= credits_d;
      error_q     <= error_d;
      done_q      <= done_d;
      rbeat_q     <= rbeat_d;
      if (lq_push) begin
        len_q[lq_wr_q] <= burst_len;
        lq_wr_q <= (lq_wr_q == QPtrW'(MAX_OUTSTANDING - 1)) ? '0 : lq_wr_q + QPtrW'(1);
      end
      if (lq_pop) begin
        lq_rd_q <= (lq_rd_q == QPtrW'(MAX_OUTSTANDING - 1)) ? '0 : lq_rd_q + QPtrW'(1);
      end
      if (lq_push && !lq_pop)      lq_cnt_q <= lq_cnt_q + QCntW'(1);
      else if (lq_pop && !lq_push) lq_cnt_q <= lq_cnt_q - QCntW'(1);
    end
  end

  readback_fifo #(
    .WIDTH (AXI_DATA_WIDTH),
    .DEPTH (FifoDepth)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (r_hs),
    .push_data (m_axi_rdata),
    .pop       (pop),
    .pop_data  (m_axis_tdata),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ddr_readback_engine.sv
// Randomized bench: AXI slave memory model with random gaps, random stream sink,
// expectations computed from the burst-splitting rules with plain arithmetic.
module tb_ddr_readback_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [34:0]  base_addr;
  logic [23:0]  beat_count;
  logic         busy, done, error;
  logic [34:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic         m_axi_arvalid, m_axi_arready;
  logic [255:0] m_axi_rdata;
  logic [1:0]   m_axi_rresp;
  logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [255:0] m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;

  always #5 clk = ~clk;

  ddr_readback_engine dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .beat_count    (beat_count),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  typedef struct packed {logic [34:0] addr; logic [8:0] len;} ar_t;
  typedef struct packed {logic [34:0] addr; logic [1:0] resp; logic last;} beat_t;

  ar_t         exp_ar[$];
  logic [34:0] exp_data[$];
  beat_t       sq[$];

  int n_checks = 0;
  int n_errors = 0;

  int ar_cnt, issued, popped, max_out, done_cnt, tlast_cnt, rready_viol, stab_viol;
  int slave_idx, err_beat, bad_last, block, cur_cnt, stall_issued;
  logic s_busy, s_error, s_done;
  logic p_arvalid, p_arready, p_tvalid, p_tready, p_tlast;
  logic [34:0] p_araddr;
  logic [7:0] p_arlen;
  logic [255:0] p_tdata;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mem_word(input logic [34:0] a);
    logic [255:0] w;
    for (int k = 0; k < 8; k++) w[k*32 +: 32] = a[31:0] ^ (32'h9E37_79B9 * 32'(k + 1));
    return w;
  endfunction

  // Expected AR sequence and stream addresses derived from the splitting rules.
  task automatic plan(input logic [34:0] base, input int cnt);
    logic [34:0] a;
    int rem, room, l;
    a = base & ~35'h1f;
    rem = cnt;
    for (int i = 0; i < cnt; i++) exp_data.push_back(a + 35'(i * 32));
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 32;
      l = 16;
      if (rem < l) l = rem;
      if (room < l) l = room;
      exp_ar.push_back('{a, 9'(l)});
      a = a + 35'(l * 32);
      rem -= l;
    end
  endtask

  // One clock: observe at negedge, apply handshake effects and drive after posedge.
  task automatic step();
    logic ar_fire, r_fire, t_fire, t_l;
    logic [34:0] ar_a;
    logic [7:0] ar_l;
    logic [255:0] t_d;
    ar_t e;
    beat_t b;
    @(negedge clk);
    s_busy = busy; s_error = error; s_done = done;
    if (busy && !m_axi_rready) rready_viol++;
    if (p_arvalid && !p_arready &&
        (!m_axi_arvalid || m_axi_araddr != p_araddr || m_axi_arlen != p_arlen)) stab_viol++;
    if (p_tvalid && !p_tready &&
        (!m_axis_tvalid || m_axis_tdata != p_tdata || m_axis_tlast != p_tlast)) stab_viol++;
    p_arvalid = m_axi_arvalid; p_arready = m_axi_arready;
    p_araddr = m_axi_araddr; p_arlen = m_axi_arlen;
    p_tvalid = m_axis_tvalid; p_tready = m_axis_tready;
    p_tdata = m_axis_tdata; p_tlast = m_axis_tlast;
    ar_fire = m_axi_arvalid && m_axi_arready;
    ar_a = m_axi_araddr; ar_l = m_axi_arlen;
    r_fire = m_axi_rvalid && m_axi_rready;
    t_fire = m_axis_tvalid && m_axis_tready;
    t_d = m_axis_tdata; t_l = m_axis_tlast;
    if (done) done_cnt++;
    @(posedge clk);
    #1;
    if (ar_fire) begin
      ar_cnt++;
      if (exp_ar.size() == 0) check_eq("ar_extra", 1, 0);
      else begin
        e = exp_ar.pop_front();
        check_eq("araddr", ar_a, e.addr);
        check_eq("arlen", ar_l, 8'(e.len - 1));
      end
      check_eq("ar_4k", (int'(ar_a[11:0]) + (int'(ar_l) + 1) * 32) <= 4096, 1);
      issued += int'(ar_l) + 1;
      for (int j = 0; j <= int'(ar_l); j++) begin
        b.addr = ar_a + 35'(j * 32);
        b.resp = (slave_idx == err_beat) ? 2'b10 : 2'b00;
        b.last = (j == int'(ar_l)) ^ (slave_idx == bad_last);
        sq.push_back(b);
        slave_idx++;
      end
    end
    if (r_fire && sq.size() > 0) void'(sq.pop_front());
    if (t_fire) begin
      if (exp_data.size() == 0) check_eq("beat_extra", 1, 0);
      else check_eq("tdata", t_d, mem_word(exp_data.pop_front()));
      check_eq("tlast", t_l, popped == cur_cnt - 1);
      if (t_l) tlast_cnt++;
      popped++;
    end
    if (issued - popped > max_out) max_out = issued - popped;
    if (block > 0) stall_issued = issued;
    m_axi_arready = 1'($urandom_range(0, 1));
    if (!(m_axi_rvalid && !r_fire)) begin
      if (sq.size() > 0 && $urandom_range(0, 3) != 0) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = mem_word(sq[0].addr);
        m_axi_rresp  = sq[0].resp;
        m_axi_rlast  = sq[0].last;
      end else begin
        m_axi_rvalid = 1'b0;
      end
    end
    if (block > 0) begin
      m_axis_tready = 1'b0;
      block--;
    end else begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic run_cmd(input logic [34:0] base, input int cnt, input int eb, input int bl,
                         input int blk, input bit busy_start, input int abort_ar,
                         input bit exp_err);
    int waited;
    exp_ar.delete(); exp_data.delete(); sq.delete();
    plan(base, cnt);
    ar_cnt = 0; issued = 0; popped = 0; max_out = 0; done_cnt = 0; tlast_cnt = 0;
    rready_viol = 0; stab_viol = 0; slave_idx = 0; stall_issued = 0;
    err_beat = eb; bad_last = bl; block = blk; cur_cnt = cnt;
    if (blk > 0) m_axis_tready = 1'b0;
    waited = exp_ar.size();
    base_addr = base; beat_count = 24'(cnt); start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("busy_go", s_busy, cnt != 0);
    check_eq("err_clr", s_error, 0);
    if (cnt == 0) check_eq("done_zero", s_done, 1);
    begin
      int n_bursts;
      n_bursts = waited;
      waited = 0;
      while (done_cnt == 0 && waited < 4000) begin
        if (busy_start && waited == 3) begin
          base_addr = 35'h9000; beat_count = 24'd5; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        step();
        waited++;
        if (abort_ar > 0 && ar_cnt >= abort_ar) begin
          rst_n = 1'b0;
          start = 1'b0;
          return;
        end
      end
      start = 1'b0;
      if (done_cnt == 0) check_eq("timeout", 0, 1);
      repeat (4) step();
      check_eq("done_cnt", done_cnt, 1);
      check_eq("ar_num", ar_cnt, n_bursts);
    end
    check_eq("ar_left", exp_ar.size(), 0);
    check_eq("beats", popped, cnt);
    check_eq("tlast_cnt", tlast_cnt, cnt > 0);
    check_eq("error", s_error, exp_err);
    check_eq("busy_end", s_busy, 0);
    check_eq("rready_viol", rready_viol, 0);
    check_eq("stab_viol", stab_viol, 0);
    check_eq("max_out", max_out <= 32, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_arvalid"}, m_axi_arvalid, 0);
    check_eq({tag, "_rready"}, m_axi_rready, 0);
    check_eq({tag, "_tvalid"}, m_axis_tvalid, 0);
    check_eq({tag, "_tlast"}, m_axis_tlast, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_error"}, error, 0);
  endtask

  task automatic clear_bus();
    sq.delete();
    m_axi_rvalid = 1'b0; m_axi_arready = 1'b0; m_axis_tready = 1'b0;
    p_arvalid = 1'b0; p_tvalid = 1'b0;
  endtask

  initial begin
    logic [34:0] rb;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; beat_count = '0;
    m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
    clear_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    check_eq("arsize", m_axi_arsize, 5);
    check_eq("arburst", m_axi_arburst, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_cmd(35'h1000, 40, -1, -1, 0, 0, 0, 0);
    run_cmd(35'h0FC0, 10, -1, -1, 0, 0, 0, 0);
    run_cmd(35'h2000, 64, -1, -1, 200, 0, 0, 0);
    check_eq("stall_issued", stall_issued, 32);
    run_cmd(35'h3000, 16, 4, -1, 0, 0, 0, 1);
    repeat (3) step();
    check_eq("err_sticky", s_error, 1);
    run_cmd(35'h5000, 16, -1, -1, 0, 0, 0, 0);
    run_cmd(35'h6000, 20, -1, 3, 0, 0, 0, 1);
    run_cmd(35'h7000, 0, -1, -1, 0, 0, 0, 0);
    run_cmd(35'h8000, 24, -1, -1, 0, 1, 0, 0);
    run_cmd(35'h0E00, 16, -1, -1, 0, 0, 0, 0);

    // Reset mid-command after the second AR handshake.
    run_cmd(35'hA000, 64, -1, -1, 0, 0, 2, 0);
    clear_bus();
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_cmd(35'hB000, 8, -1, -1, 0, 0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      rb = 35'($urandom) & 35'h0_000F_FFE0;
      run_cmd(rb, $urandom_range(1, 70), -1, -1, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
